// File: rtl/sec32_encoder_pipe.sv
// Two-stage pipelined SEC check-bit generator for 32-bit words, with
// single-bit error injection for exercising the corrector and a delivered-word counter.
module sec32_encoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             Gclk,
    input  logic             Grst_n,
    input  logic             Gin_valid,
    output logic             Gin_ready,
    input  logic [31:0]      Gin_data,
    input  logic             Ginj_req,
    input  logic [5:0]       Ginj_idx,
    output logic             Gout_valid,
    input  logic             Gout_ready,
    output logic [31:0]      Gout_data,
    output logic [7:0]       Gout_chk,
    output logic             Gout_inj,
    output logic [CNT_W-1:0] Gword_cnt
);

    logic        s1_v;
    logic [31:0] s1_data;
    logic [7:0]  s1_f;
    logic [7:0]  s1_xe;
    logic        s1_inj;
    logic [5:0]  s1_idx;

    logic        s2_v;
    logic [31:0] s2_data;
    logic [7:0]  s2_chk;
    logic        s2_inj;

    logic        armed;
    logic [5:0]  arm_idx;

    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;
    logic        idx_ok;
    logic        eff_armed;
    logic [5:0]  eff_idx;

    logic [7:0]  f_in;
    logic [7:0]  xe_in;
    logic [7:0]  g;
    logic [7:0]  chk_clean;
    logic [31:0] data_mask;
    logic [7:0]  chk_mask;

    assign s1_adv     = !s2_v || Gout_ready;
    assign Gin_ready  = !s1_v || s1_adv;
    assign in_fire    = Gin_valid && Gin_ready;
    assign out_fire   = s2_v && Gout_ready;
    assign Gout_valid = s2_v;
    assign Gout_data  = s2_data;
    assign Gout_chk   = s2_chk;
    assign Gout_inj   = s2_inj;

    // A request in the same cycle as an accepted word takes effect on that word.
    assign idx_ok    = (Ginj_idx < 6'd40);
    assign eff_armed = Ginj_req ? idx_ok : armed;
    assign eff_idx   = Ginj_req ? Ginj_idx : arm_idx;

    always_comb begin
        f_in  = '0;
        xe_in = '0;
        for (int j = 0; j < 8; j++) begin
            f_in[j] = Gin_data[4*j] ^ Gin_data[4*j+1] ^ Gin_data[4*j+2] ^ Gin_data[4*j+3];
        end
        for (int k = 0; k < 4; k++) begin
            xe_in[k] = Gin_data[k] ^ Gin_data[k+4] ^ Gin_data[k+8] ^ Gin_data[k+12];
        end
        for (int k = 4; k < 8; k++) begin
            xe_in[k] = Gin_data[k+12] ^ Gin_data[k+16] ^ Gin_data[k+20] ^ Gin_data[k+24];
        end
    end

    // Check bits come from the clean data; the flip is applied afterwards.
    always_comb begin
        g[0] = s1_f[0] ^ s1_f[1];
        g[1] = s1_f[2] ^ s1_f[3];
        g[2] = s1_f[0] ^ s1_f[2];
        g[3] = s1_f[1] ^ s1_f[3];
        g[4] = s1_f[4] ^ s1_f[5];
        g[5] = s1_f[6] ^ s1_f[7];
        g[6] = s1_f[4] ^ s1_f[6];
        g[7] = s1_f[5] ^ s1_f[7];
        chk_clean = {s1_xe[7:4] ^ g[3:0], s1_xe[3:0] ^ g[7:4]};
        data_mask = '0;
        chk_mask  = '0;
        if (s1_inj && !s1_idx[5]) begin
            data_mask = 32'h1 << s1_idx[4:0];
        end
        if (s1_inj && s1_idx[5]) begin
            chk_mask = 8'h1 << s1_idx[2:0];
        end
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            armed   <= 1'b0;
            arm_idx <= '0;
        end else if (in_fire) begin
            armed   <= 1'b0;
        end else if (Ginj_req) begin
            armed   <= idx_ok;
            arm_idx <= Ginj_idx;
        end
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_f    <= '0;
            s1_xe   <= '0;
            s1_inj  <= 1'b0;
            s1_idx  <= '0;
        end else if (in_fire) begin
            s1_v    <= 1'b1;
            s1_data <= Gin_data;
            s1_f    <= f_in;
            s1_xe   <= xe_in;
            s1_inj  <= eff_armed;
            s1_idx  <= eff_idx;
        end else if (s1_adv) begin
            s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_chk  <= '0;
            s2_inj  <= 1'b0;
        end else if (s1_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= s1_data ^ data_mask;
                s2_chk  <= chk_clean ^ chk_mask;
                s2_inj  <= s1_inj;
            end
        end
    end

    always_ff @(posedge Gclk or negedge Grst_n) begin
        if (!Grst_n) begin
            Gword_cnt <= '0;
        end else if (out_fire) begin
            Gword_cnt <= Gword_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sec32_encoder_pipe.sv
// Scoreboard bench for sec32_encoder_pipe: reference encoder, injector model and
// SEC corrector model; a second instance with a 4-bit counter covers wrap-around.
module tb_sec32_encoder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        inj_req;
    logic [5:0]  inj_idx;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_chk;
    logic        out_inj;
    logic [15:0] word_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic [7:0]  out_chk4;
    logic        out_inj4;
    logic [3:0]  word_cnt4;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  chk;
        logic        inj;
        logic [31:0] clean;
    } exp_t;

    exp_t sb[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int stallCount  = 0;
    int expCnt      = 0;

    logic        mArmed = 1'b0;
    logic [5:0]  mIdx   = '0;
    logic        havePrev = 1'b0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData;
    logic [7:0]  prevChk;
    logic        prevInj;
    logic        toggleDone;

    sec32_encoder_pipe #(.CNT_W(16)) dut (
        .Gclk(clk), .Grst_n(rst_n),
        .Gin_valid(in_valid), .Gin_ready(in_ready), .Gin_data(in_data),
        .Ginj_req(inj_req), .Ginj_idx(inj_idx),
        .Gout_valid(out_valid), .Gout_ready(out_ready),
        .Gout_data(out_data), .Gout_chk(out_chk), .Gout_inj(out_inj),
        .Gword_cnt(word_cnt)
    );

    sec32_encoder_pipe #(.CNT_W(4)) dut4 (
        .Gclk(clk), .Grst_n(rst_n),
        .Gin_valid(in_valid), .Gin_ready(in_ready4), .Gin_data(in_data),
        .Ginj_req(inj_req), .Ginj_idx(inj_idx),
        .Gout_valid(out_valid4), .Gout_ready(out_ready),
        .Gout_data(out_data4), .Gout_chk(out_chk4), .Gout_inj(out_inj4),
        .Gword_cnt(word_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] encRef(input logic [31:0] d);
        logic [7:0] f, xe, g, c;
        for (int j = 0; j < 8; j++) f[j] = ^d[4*j +: 4];
        for (int k = 0; k < 4; k++) xe[k] = d[k] ^ d[k+4] ^ d[k+8] ^ d[k+12];
        for (int k = 4; k < 8; k++) xe[k] = d[k+12] ^ d[k+16] ^ d[k+20] ^ d[k+24];
        g = {f[5]^f[7], f[4]^f[6], f[6]^f[7], f[4]^f[5],
             f[1]^f[3], f[0]^f[2], f[2]^f[3], f[0]^f[1]};
        c[3:0] = xe[3:0] ^ g[7:4];
        c[7:4] = xe[7:4] ^ g[3:0];
        return c;
    endfunction

    // Corrector model: a nonzero syndrome matching a data column flips that bit.
    function automatic logic [31:0] correctRef(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  s;
        logic [31:0] one;
        logic [31:0] r;
        s = c ^ encRef(d);
        r = d;
        if (s != 8'h00) begin
            for (int i = 0; i < 32; i++) begin
                one = 32'h1 << i;
                if (encRef(one) == s) r = d ^ one;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes are decided by the values held just before the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mArmed    = 1'b0;
            expCnt    = 0;
            havePrev  = 1'b0;
            prevStall = 1'b0;
        end else begin
            exp_t e;
            logic       effArmed;
            logic [5:0] effIdx;
            if (havePrev && prevStall) begin
                checkOutput("stall_valid", {31'b0, out_valid}, 32'h1);
                checkOutput("stall_data", out_data, prevData);
                checkOutput("stall_chk", {24'b0, out_chk}, {24'b0, prevChk});
                checkOutput("stall_inj", {31'b0, out_inj}, {31'b0, prevInj});
            end
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(sb.size() == 2 && !out_ready)});
            checkOutput("word_cnt", {16'b0, word_cnt}, expCnt & 32'hFFFF);
            checkOutput("word_cnt4", {28'b0, word_cnt4}, expCnt & 32'hF);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_word", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_chk", {24'b0, out_chk}, {24'b0, e.chk});
                    checkOutput("out_inj", {31'b0, out_inj}, {31'b0, e.inj});
                    checkOutput("corrected", correctRef(out_data, out_chk), e.clean);
                end
                expCnt++;
            end
            if (in_valid && in_ready) begin
                effArmed = inj_req ? (inj_idx < 6'd40) : mArmed;
                effIdx   = inj_req ? inj_idx : mIdx;
                e.clean  = in_data;
                e.data   = in_data;
                e.chk    = encRef(in_data);
                e.inj    = effArmed;
                if (effArmed && effIdx < 6'd32) e.data = in_data ^ (32'h1 << effIdx);
                if (effArmed && effIdx >= 6'd32) e.chk = e.chk ^ (8'h1 << (effIdx - 6'd32));
                sb.push_back(e);
                mArmed = 1'b0;
            end else if (inj_req) begin
                mArmed = (inj_idx < 6'd40);
                mIdx   = inj_idx;
            end
            havePrev  = 1'b1;
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevChk   = out_chk;
            prevInj   = out_inj;
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic doInj, input logic [5:0] idx);
        logic got;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        inj_req  = doInj;
        inj_idx  = idx;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            inj_req = 1'b0;
            if (!got) stallCount++;
            n++;
        end
        if (!got) checkOutput("accept_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic armInj(input logic [5:0] idx);
        inj_req = 1'b1;
        inj_idx = idx;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] vecData [4] = '{32'h00000000, 32'h00000001, 32'h00010000, 32'hFFFFFFFF};
    logic [7:0]  vecChk  [4] = '{8'h00, 8'h51, 8'h15, 8'h00};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        inj_req   = 1'b0;
        inj_idx   = '0;
        out_ready = 1'b1;
        toggleDone = 1'b0;
        #1;
        checkOutput("rst_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_data", out_data, 32'h0);
        checkOutput("rst_chk", {24'b0, out_chk}, 32'h0);
        checkOutput("rst_inj", {31'b0, out_inj}, 32'h0);
        checkOutput("rst_cnt", {16'b0, word_cnt}, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Known vectors: invisible after the accepting edge, presented after the next.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecData[i], 1'b0, 6'd0);
            checkOutput("lat_early", {31'b0, out_valid}, 32'h0);
            @(posedge clk);
            #1;
            checkOutput("lat_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("vec_chk", {24'b0, out_chk}, {24'b0, vecChk[i]});
            waitDrain();
        end

        // Full-throughput stream from a clean counter.
        doReset();
        stallCount = 0;
        for (int i = 0; i < 100; i++) applyStimulus($urandom, 1'b0, 6'd0);
        checkOutput("stream_stalls", stallCount, 0);
        waitDrain();
        checkOutput("stream_cnt", {16'b0, word_cnt}, 32'd100);

        // Random backpressure.
        fork
            begin
                for (int i = 0; i < 60; i++) applyStimulus($urandom, 1'b0, 6'd0);
                toggleDone = 1'b1;
            end
            begin
                while (!toggleDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 1);
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Data-bit injection armed ahead of the word, then a clean follower.
        armInj(6'd5);
        applyStimulus(32'h12345678, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("inj5_data", out_data, 32'h12345658);
        checkOutput("inj5_chk", {24'b0, out_chk}, {24'b0, encRef(32'h12345678)});
        checkOutput("inj5_flag", {31'b0, out_inj}, 32'h1);
        checkOutput("inj5_fixed", correctRef(out_data, out_chk), 32'h12345678);
        applyStimulus(32'h12345678, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("after_inj_data", out_data, 32'h12345678);
        checkOutput("after_inj_flag", {31'b0, out_inj}, 32'h0);
        waitDrain();

        // Check-bit injection requested in the accepting cycle.
        applyStimulus(32'hA5A5A5A5, 1'b1, 6'd33);
        @(posedge clk);
        #1;
        checkOutput("inj33_chk", {24'b0, out_chk}, {24'b0, encRef(32'hA5A5A5A5) ^ 8'h02});
        checkOutput("inj33_flag", {31'b0, out_inj}, 32'h1);
        waitDrain();

        // Out-of-range index cancels an earlier arm.
        armInj(6'd7);
        armInj(6'd45);
        applyStimulus(32'hDEADBEEF, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("inj45_data", out_data, 32'hDEADBEEF);
        checkOutput("inj45_flag", {31'b0, out_inj}, 32'h0);
        waitDrain();

        // Reset with both stages full.
        out_ready = 1'b0;
        applyStimulus(32'h11111111, 1'b0, 6'd0);
        applyStimulus(32'h22222222, 1'b0, 6'd0);
        #1;
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("midrst_cnt", {16'b0, word_cnt}, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_stale", {31'b0, out_valid}, 32'h0);
        end
        checkOutput("post_rst_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Narrow counter wrap.
        for (int i = 0; i < 17; i++) applyStimulus($urandom, 1'b0, 6'd0);
        waitDrain();
        checkOutput("wrap_cnt4", {28'b0, word_cnt4}, 32'd1);
        checkOutput("wrap_cnt16", {16'b0, word_cnt}, 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
